// File: rtl/incr_square_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : incr_square_pipe
//  Description : Pipelined (y + INCR)^2 with valid/ready flow control,
//                overflow flag and optional saturation.
//  Revision    : 1.0 - initial pipelined release
// ============================================================================
module incr_square_pipe #(
    parameter int          WIDTH    = 32,
    parameter logic [63:0] INCR     = 64'd1,
    parameter int          LATENCY  = 3,
    parameter int          SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             overflow,
    output logic             busy
);

    localparam int           c_prod_w = 2 * WIDTH + 2;
    localparam logic [WIDTH:0] c_incr = {1'b0, INCR[WIDTH-1:0]};

    logic                 r_live;
    logic [LATENCY-1:0]   r_vld;
    logic [LATENCY-1:0]   w_rdy;
    logic                 w_in_fire;
    logic [WIDTH:0]       w_sum;
    logic [WIDTH:0]       w_sq_src;
    logic                 w_out_load;
    logic [c_prod_w-1:0]  w_prod;
    logic                 w_ovf;
    logic [WIDTH-1:0]     w_res;
    logic [WIDTH-1:0]     r_out;
    logic                 r_ovf;

    // Stall chain: a stage can load when it is empty or its contents move on.
    assign w_rdy[LATENCY-1] = !r_vld[LATENCY-1] || out_ready;

    for (genvar k = 0; k < LATENCY - 1; k++) begin : g_rdy
        assign w_rdy[k] = !r_vld[k] || w_rdy[k+1];
    end

    // r_live holds in_ready low until the first edge after reset release.
    assign in_ready  = r_live && w_rdy[0];
    assign w_in_fire = in_valid && in_ready;

    // Sum is kept one bit wider so y + INCR never wraps.
    assign w_sum = {1'b0, y} + c_incr;

    // Squaring happens between the last sum stage and the output register.
    assign w_prod = {{(WIDTH+1){1'b0}}, w_sq_src} * {{(WIDTH+1){1'b0}}, w_sq_src};
    assign w_ovf  = |w_prod[c_prod_w-1:WIDTH];
    assign w_res  = ((SATURATE != 0) && w_ovf) ? {WIDTH{1'b1}} : w_prod[WIDTH-1:0];

    if (LATENCY == 1) begin : g_lat1
        assign w_sq_src   = w_sum;
        assign w_out_load = w_in_fire;
    end else begin : g_latn
        logic [WIDTH:0] r_sum [LATENCY-1];

        // Sum shift stages; data only moves alongside a valid token.
        always_ff @(posedge clk) begin
            if (w_in_fire) begin
                r_sum[0] <= w_sum;
            end
            for (int k = 1; k < LATENCY - 1; k++) begin
                if (w_rdy[k] && r_vld[k-1]) begin
                    r_sum[k] <= r_sum[k-1];
                end
            end
        end

        assign w_sq_src   = r_sum[LATENCY-2];
        assign w_out_load = w_rdy[LATENCY-1] && r_vld[LATENCY-2];
    end

    // Becomes 1 on the first edge after reset release and stays there.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live <= 1'b0;
        end else begin
            r_live <= 1'b1;
        end
    end

    // Stage valid bits; empty stages take from behind so bubbles collapse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else begin
            if (w_rdy[0]) begin
                r_vld[0] <= w_in_fire;
            end
            for (int k = 1; k < LATENCY; k++) begin
                if (w_rdy[k]) begin
                    r_vld[k] <= r_vld[k-1];
                end
            end
        end
    end

    // Output register; only loads when the last stage can take new data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
            r_ovf <= 1'b0;
        end else if (w_out_load) begin
            r_out <= w_res;
            r_ovf <= w_ovf;
        end
    end

    assign out_valid = r_vld[LATENCY-1];
    assign out       = r_out;
    assign overflow  = r_ovf;
    assign busy      = |r_vld;

endmodule
`default_nettype wire

// File: tb/tb_incr_square_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_incr_square_pipe
//  Description : Scoreboard bench for incr_square_pipe across four configs
//                (W32/L3, W8/L1, W8/L4 saturating, W12/L8 INCR=5).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_incr_square_pipe;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] y     = '0;
    logic [3:0]  vin   = '0;
    logic        ordy  = 1'b0;
    logic [3:0]  ir, ov, of, bz;
    logic [31:0] o0;
    logic [7:0]  o1, o2;
    logic [11:0] o3;
    logic [63:0] obs [4];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    bit lat_chk = 1'b0;

    typedef struct {
        logic [63:0] v;
        int          c;
    } sb_t;

    sb_t         sbq [4][$];
    logic [63:0] olog [4][$];
    int          acc_cnt [4] = '{default: 0};
    int          out_cnt [4] = '{default: 0};
    bit          prev_stall [4] = '{default: 0};
    logic [63:0] prev_val [4];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    incr_square_pipe #(.WIDTH(32), .INCR(64'd1), .LATENCY(3), .SATURATE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(vin[0]), .in_ready(ir[0]), .y(y[31:0]),
        .out_valid(ov[0]), .out_ready(ordy), .out(o0), .overflow(of[0]), .busy(bz[0]));
    incr_square_pipe #(.WIDTH(8), .INCR(64'd1), .LATENCY(1), .SATURATE(0)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(vin[1]), .in_ready(ir[1]), .y(y[7:0]),
        .out_valid(ov[1]), .out_ready(ordy), .out(o1), .overflow(of[1]), .busy(bz[1]));
    incr_square_pipe #(.WIDTH(8), .INCR(64'd1), .LATENCY(4), .SATURATE(1)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(vin[2]), .in_ready(ir[2]), .y(y[7:0]),
        .out_valid(ov[2]), .out_ready(ordy), .out(o2), .overflow(of[2]), .busy(bz[2]));
    incr_square_pipe #(.WIDTH(12), .INCR(64'd5), .LATENCY(8), .SATURATE(0)) u_d (
        .clk(clk), .rst_n(rst_n), .in_valid(vin[3]), .in_ready(ir[3]), .y(y[11:0]),
        .out_valid(ov[3]), .out_ready(ordy), .out(o3), .overflow(of[3]), .busy(bz[3]));

    // Observed result packed as {overflow, out} with overflow at bit 32.
    always_comb begin
        obs[0] = {31'd0, of[0], o0};
        obs[1] = {31'd0, of[1], 24'd0, o1};
        obs[2] = {31'd0, of[2], 24'd0, o2};
        obs[3] = {31'd0, of[3], 20'd0, o3};
    end

    function automatic int lat_of(input int i);
        case (i)
            0:       return 3;
            1:       return 1;
            2:       return 4;
            default: return 8;
        endcase
    endfunction

    // Reference model at 128 bits: wide enough that nothing wraps.
    function automatic logic [63:0] model(input int i, input logic [63:0] yv);
        int           w;
        bit           sat;
        logic [127:0] inc, m, s, p, o;
        bit           ovf;
        case (i)
            0:       begin w = 32; inc = 128'd1; sat = 0; end
            1:       begin w = 8;  inc = 128'd1; sat = 0; end
            2:       begin w = 8;  inc = 128'd1; sat = 1; end
            default: begin w = 12; inc = 128'd5; sat = 0; end
        endcase
        m   = (128'd1 << w) - 128'd1;
        s   = ({64'd0, yv} & m) + inc;
        p   = s * s;
        ovf = (p >> w) != 128'd0;
        o   = (sat && ovf) ? m : (p & m);
        return {31'd0, ovf, o[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic chk_log(input int i, input string tag, input logic [63:0] exp[$]);
        chk({tag, "_count"}, 64'(olog[i].size()), 64'(exp.size()));
        if (olog[i].size() == exp.size()) begin
            for (int k = 0; k < exp.size(); k++) begin
                chk(tag, olog[i][k], exp[k]);
            end
        end
    endtask

    // Scoreboard monitor, sampled mid-cycle: pop on output transfer, then
    // push on input transfer, and check that stalled outputs stay put.
    always @(negedge clk) begin : mon
        sb_t e;
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                sbq[i].delete();
                prev_stall[i] = 0;
            end else begin
                if (prev_stall[i]) chk("hold_stable", obs[i], prev_val[i]);
                if (ov[i] && ordy) begin
                    out_cnt[i]++;
                    olog[i].push_back(obs[i]);
                    if (sbq[i].size() == 0) begin
                        chk("spurious_out", 64'd1, 64'd0);
                    end else begin
                        e = sbq[i].pop_front();
                        chk("data", obs[i], e.v);
                        if (lat_chk) chk("latency", 64'(cyc + 1 - e.c), 64'(lat_of(i)));
                    end
                end
                if (vin[i] && ir[i]) begin
                    sbq[i].push_back('{model(i, y), cyc + 1});
                    acc_cnt[i]++;
                end
                prev_stall[i] = ov[i] && !ordy;
                prev_val[i]   = obs[i];
            end
        end
    end

    // Present v on the selected instances until one of them accepts it.
    task automatic send(input logic [3:0] m, input logic [63:0] v);
        bit done = 0;
        y   = v;
        vin = m;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clk);
            done = (vin & ir) != 4'd0;
            @(posedge clk);
            #1;
        end
        if (!done) chk("send_timeout", 64'd0, 64'd1);
        vin = '0;
    endtask

    task automatic wait_idle(input logic [3:0] m);
        bit done = 0;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            done = (bz & m) == 4'd0;
        end
        if (!done) chk("idle_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] exp[$];

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", 64'(ov), 64'd0);
        chk("rst_busy", 64'(bz), 64'd0);
        chk("rst_overflow", 64'(of), 64'd0);
        chk("rst_out_a", 64'(o0), 64'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("in_ready_after_rst", 64'(ir), 64'hF);
        @(posedge clk); #1;

        // Back-to-back accepts on the 32-bit pipe
        ordy = 1'b1; lat_chk = 1'b1;
        olog[0].delete();
        send(4'b0001, 64'd10);
        send(4'b0001, 64'd3);
        wait_idle(4'b0001);
        exp = '{64'd121, 64'd16};
        chk_log(0, "w32_basic", exp);

        // 8-bit wrapping
        olog[1].delete();
        send(4'b0010, 64'd15);
        send(4'b0010, 64'd255);
        send(4'b0010, 64'd14);
        wait_idle(4'b0010);
        exp = '{64'h1_0000_0000, 64'h1_0000_0000, 64'd225};
        chk_log(1, "w8_wrap", exp);

        // 8-bit saturating
        olog[2].delete();
        send(4'b0100, 64'd15);
        send(4'b0100, 64'd14);
        wait_idle(4'b0100);
        exp = '{64'h1_0000_00FF, 64'd225};
        chk_log(2, "w8_sat", exp);

        // Backpressure: fill to LATENCY entries, then release
        ordy = 1'b0; lat_chk = 1'b0;
        olog[0].delete();
        acc_cnt[0] = 0;
        fork
            begin
                for (int v = 0; v < 10; v++) send(4'b0001, 64'(v));
            end
            begin
                repeat (6) @(posedge clk);
                @(negedge clk);
                chk("bp_accepts", 64'(acc_cnt[0]), 64'd3);
                chk("bp_in_ready", 64'(ir[0]), 64'd0);
                chk("bp_out_valid", 64'(ov[0]), 64'd1);
                chk("bp_out", 64'(o0), 64'd1);
                @(posedge clk); #1 ordy = 1'b1;
            end
        join
        wait_idle(4'b0001);
        exp.delete();
        for (int v = 1; v <= 10; v++) exp.push_back(64'(v * v));
        chk_log(0, "bp_order", exp);

        // Random traffic on L=1, L=4, L=8 instances
        for (int i = 0; i < 4; i++) out_cnt[i] = 0;
        for (int t = 0; t < 20000; t++) begin
            if (out_cnt[1] >= 1000 && out_cnt[2] >= 1000 && out_cnt[3] >= 1000) break;
            vin  = 4'b1110 & 4'($urandom);
            y    = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 20));
            ordy = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        vin = '0; ordy = 1'b1;
        wait_idle(4'b1110);
        for (int i = 1; i < 4; i++) begin
            chk("rand_count", 64'(out_cnt[i] >= 1000), 64'd1);
            chk("rand_drained", 64'(sbq[i].size()), 64'd0);
        end

        // Asynchronous reset with two results in flight
        ordy = 1'b0;
        olog[0].delete();
        send(4'b0001, 64'hFFFF_FFFF);
        send(4'b0001, 64'h0001_0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_valid", 64'(ov[0]), 64'd1);
        chk("pre_rst_ovf", 64'(of[0]), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 64'(ov[0]), 64'd0);
        chk("async_rst_busy", 64'(bz[0]), 64'd0);
        chk("async_rst_ovf", 64'(of[0]), 64'd0);
        chk("async_rst_out", 64'(o0), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b1; lat_chk = 1'b1;
        send(4'b0001, 64'd3);
        wait_idle(4'b0001);
        repeat (4) @(posedge clk);
        #1;
        exp = '{64'd16};
        chk_log(0, "post_rst", exp);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
